// File: rtl/hemaia_clk_div_pkg.sv
// Shared definitions for the HeMAiA clock divider: divisor width limit,
// divisor classification helpers and the output-path mode encoding.
package hemaia_clk_div_pkg;

  localparam int unsigned MaxDivisorWidth = 16;

  typedef enum logic [1:0] {
    ModeGated  = 2'd0,
    ModeBypass = 2'd1,
    ModeEven   = 2'd2,
    ModeOdd    = 2'd3
  } div_mode_e;

  function automatic logic is_bypass(input logic [MaxDivisorWidth-1:0] d);
    return (d == MaxDivisorWidth'(1));
  endfunction

  function automatic logic is_gated(input logic [MaxDivisorWidth-1:0] d);
    return (d == MaxDivisorWidth'(0));
  endfunction

  function automatic div_mode_e div_mode(input logic [MaxDivisorWidth-1:0] d);
    div_mode_e mode;
    if (is_gated(d)) begin
      mode = ModeGated;
    end else if (is_bypass(d)) begin
      mode = ModeBypass;
    end else if (d[0]) begin
      mode = ModeOdd;
    end else begin
      mode = ModeEven;
    end
    return mode;
  endfunction

endpackage

// File: rtl/hemaia_clock_counter.sv
// Wrapping period counter 0..max_i with synchronous clear; exposes the next
// count so callers can register decodes aligned with the count itself.
module hemaia_clock_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_next_o,
  output logic             wrap_o
);

  logic [Width-1:0] r_cnt;
  logic [Width-1:0] w_cnt_next;

  // A count beyond max_i is treated as a wrap so a corrupted state recovers.
  assign wrap_o = en_i & (r_cnt >= max_i);

  always_comb begin
    w_cnt_next = r_cnt;
    if (clear_i) begin
      w_cnt_next = '0;
    end else if (wrap_o) begin
      w_cnt_next = '0;
    end else if (en_i) begin
      w_cnt_next = r_cnt + Width'(1);
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt_o      = r_cnt;
  assign cnt_next_o = w_cnt_next;

endmodule

// File: rtl/hemaia_multi_clock_divider_channel.sv
// One divider channel: divisor handshake with period-boundary apply, period
// counter, 50%-duty shaping flops and a glitch-free output path.
module hemaia_clock_divider_channel #(
  parameter int unsigned DivWidth        = 8,
  parameter int unsigned DefaultDivision = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic [DivWidth-1:0] divisor_i,
  input  logic                divisor_valid_i,
  output logic                divisor_ready_o,
  input  logic                sync_i,
  output logic                clk_o,
  output logic                period_start_o,
  output logic                busy_o
);
  import hemaia_clk_div_pkg::*;

  logic [DivWidth-1:0] r_divisor;
  logic [DivWidth-1:0] r_shadow;
  logic                r_pending;
  logic                r_period_start;
  logic                r_raw_d1;
  logic                r_raw_d2;

  logic [DivWidth-1:0] w_cnt;
  logic [DivWidth-1:0] w_cnt_next;
  logic [DivWidth-1:0] w_cnt_max;
  logic [DivWidth-1:0] w_div_next;
  logic                w_div_ge2;
  logic                w_wrap;
  logic                w_accept;
  logic                w_apply;
  logic                w_raw;
  logic                w_period_start_next;
  div_mode_e           w_mode;
  logic                w_sel_clk;
  logic                w_sel_odd;
  logic                w_gate_en;
  logic                w_odd_clk;
  logic                w_shaped_clk;
  logic                w_mux_clk;

  assign w_div_ge2  = (r_divisor >= DivWidth'(2));
  assign w_cnt_max  = w_div_ge2 ? (r_divisor - DivWidth'(1)) : '0;
  assign w_accept   = divisor_valid_i & ~r_pending;
  assign w_apply    = r_pending & (w_wrap | ~w_div_ge2 | sync_i);
  assign w_div_next = w_apply ? r_shadow : r_divisor;

  hemaia_clock_counter #(
    .Width(DivWidth)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (w_apply | sync_i),
    .en_i       (w_div_ge2),
    .max_i      (w_cnt_max),
    .cnt_o      (w_cnt),
    .cnt_next_o (w_cnt_next),
    .wrap_o     (w_wrap)
  );

  // Shadow capture and divisor apply; accept and apply are mutually exclusive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_divisor <= DivWidth'(DefaultDivision);
      r_shadow  <= DivWidth'(DefaultDivision);
      r_pending <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow  <= divisor_i;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      r_divisor <= w_div_next;
    end
  end

  always_comb begin
    w_period_start_next = 1'b0;
    if (is_bypass(MaxDivisorWidth'(w_div_next))) begin
      w_period_start_next = 1'b1;
    end else if (w_div_next >= DivWidth'(2)) begin
      w_period_start_next = (w_cnt_next == '0);
    end else begin
      w_period_start_next = 1'b0;
    end
  end

  assign w_raw = (w_cnt >= (r_divisor >> 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_period_start <= 1'b0;
      r_raw_d1       <= 1'b1;
    end else begin
      r_period_start <= w_period_start_next;
      r_raw_d1       <= w_raw;
    end
  end

  // Half-cycle delayed copy stretches odd divisors to exact 50% duty.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_raw_d2 <= 1'b1;
    end else begin
      r_raw_d2 <= r_raw_d1;
    end
  end

  // Divisor 0 routes clk_i into the gate so its enable latch keeps updating.
  assign w_mode    = div_mode(MaxDivisorWidth'(r_divisor));
  assign w_sel_clk = (w_mode == ModeBypass) | (w_mode == ModeGated);
  assign w_sel_odd = (w_mode == ModeOdd);
  assign w_gate_en = (w_mode != ModeGated);
  assign w_odd_clk = r_raw_d1 & r_raw_d2;

  tc_clk_mux2 u_odd_mux (
    .clk0_i    (r_raw_d1),
    .clk1_i    (w_odd_clk),
    .clk_sel_i (w_sel_odd),
    .clk_o     (w_shaped_clk)
  );

  tc_clk_mux2 u_bypass_mux (
    .clk0_i    (w_shaped_clk),
    .clk1_i    (clk_i),
    .clk_sel_i (w_sel_clk),
    .clk_o     (w_mux_clk)
  );

  tc_clk_gating u_gate (
    .clk_i     (w_mux_clk),
    .en_i      (w_gate_en),
    .test_en_i (test_mode_i),
    .clk_o     (clk_o)
  );

  assign divisor_ready_o = ~r_pending;
  assign busy_o          = r_pending;
  assign period_start_o  = r_period_start;

endmodule

// File: rtl/tc_clk.sv
// Behavioural models of the technology clock cells: a glitch-free 2:1 clock
// mux and a latch-based integrated clock gate with DFT override.
module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);

  assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_en;

  // Enable latch is transparent only while the clock is low, so the gate
  // can never truncate a high phase.
  always_latch begin
    if (!clk_i) begin
      r_en = en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & r_en;

endmodule

// File: rtl/hemaia_multi_clock_divider.sv
// N-channel integer clock divider; channels are independent except for the
// shared sync_i phase realignment.
module hemaia_multi_clock_divider #(
  parameter int unsigned NumChannels      = 4,
  parameter int unsigned MaxDivisionWidth = 8,
  parameter int unsigned DefaultDivision  = 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         test_mode_i,
  input  logic [NumChannels-1:0][MaxDivisionWidth-1:0] divisor_i,
  input  logic [NumChannels-1:0]                       divisor_valid_i,
  output logic [NumChannels-1:0]                       divisor_ready_o,
  input  logic                                         sync_i,
  output logic [NumChannels-1:0]                       clk_o,
  output logic [NumChannels-1:0]                       period_start_o,
  output logic [NumChannels-1:0]                       busy_o
);
  import hemaia_clk_div_pkg::*;

  logic w_sync;

  assign w_sync = sync_i;

  for (genvar g = 0; g < NumChannels; g++) begin : gen_ch
    hemaia_clock_divider_channel #(
      .DivWidth        (MaxDivisionWidth),
      .DefaultDivision (DefaultDivision)
    ) u_ch (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .test_mode_i     (test_mode_i),
      .divisor_i       (divisor_i[g]),
      .divisor_valid_i (divisor_valid_i[g]),
      .divisor_ready_o (divisor_ready_o[g]),
      .sync_i          (w_sync),
      .clk_o           (clk_o[g]),
      .period_start_o  (period_start_o[g]),
      .busy_o          (busy_o[g])
    );
  end

endmodule

// File: tb/tb_hemaia_multi_clock_divider.sv
// Directed bench for hemaia_multi_clock_divider: duty-cycle vector table plus
// handshake, gating, sync and mid-period reset sequences.
module tb_hemaia_multi_clock_divider;

  localparam int NCh = 4;
  localparam int W   = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    test_mode_i;
  logic [NCh-1:0][W-1:0]   divisor_i;
  logic [NCh-1:0]          divisor_valid_i;
  logic [NCh-1:0]          divisor_ready_o;
  logic                    sync_i;
  logic [NCh-1:0]          clk_o;
  logic [NCh-1:0]          period_start_o;
  logic [NCh-1:0]          busy_o;

  int checks   = 0;
  int failures = 0;
  int hi, lo;

  typedef struct {
    logic [W-1:0] div;
    int           exp_hi;
    int           exp_lo;
  } vec_t;

  vec_t vecs [9];

  always #5 clk_i = ~clk_i;

  hemaia_multi_clock_divider #(
    .NumChannels      (NCh),
    .MaxDivisionWidth (W),
    .DefaultDivision  (1)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .test_mode_i     (test_mode_i),
    .divisor_i       (divisor_i),
    .divisor_valid_i (divisor_valid_i),
    .divisor_ready_o (divisor_ready_o),
    .sync_i          (sync_i),
    .clk_o           (clk_o),
    .period_start_o  (period_start_o),
    .busy_o          (busy_o)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic half();
    @(clk_i);
    #2;
  endtask

  // High/low length of one clk_o period, in clk_i half-periods.
  task automatic measure(input int ch, output int h, output int l);
    int   guard;
    logic prev;
    guard = 0; h = 0; l = 0;
    half();
    prev = clk_o[ch];
    half();
    while (!(!prev && clk_o[ch]) && guard < 100) begin
      prev = clk_o[ch];
      half();
      guard++;
    end
    while (clk_o[ch] && guard < 200) begin
      h++;
      half();
      guard++;
    end
    while (!clk_o[ch] && guard < 300) begin
      l++;
      half();
      guard++;
    end
  endtask

  task automatic request(input int ch, input logic [W-1:0] d);
    int g = 0;
    while (!divisor_ready_o[ch] && g < 64) begin
      tick();
      g++;
    end
    divisor_i[ch]       = d;
    divisor_valid_i[ch] = 1'b1;
    tick();
    divisor_valid_i[ch] = 1'b0;
  endtask

  task automatic set_div(input int ch, input logic [W-1:0] d);
    int g = 0;
    request(ch, d);
    while (busy_o[ch] && g < 64) begin
      tick();
      g++;
    end
    check($sformatf("ch%0d apply d=%0d", ch, d), busy_o[ch], 0);
  endtask

  initial begin
    int g, busy_cycles, highs, both, n0, n1;

    vecs[0] = '{8'd4, 4, 4};
    vecs[1] = '{8'd3, 3, 3};
    vecs[2] = '{8'd2, 2, 2};
    vecs[3] = '{8'd5, 5, 5};
    vecs[4] = '{8'd6, 6, 6};
    vecs[5] = '{8'd7, 7, 7};
    vecs[6] = '{8'd8, 8, 8};
    vecs[7] = '{8'd9, 9, 9};
    vecs[8] = '{8'd1, 1, 1};

    rst_ni          = 1'b0;
    test_mode_i     = 1'b0;
    divisor_i       = '0;
    divisor_valid_i = '0;
    sync_i          = 1'b0;

    repeat (3) tick();
    check("reset ready", divisor_ready_o, 4'hF);
    check("reset busy", busy_o, 4'h0);
    check("reset period_start", period_start_o, 4'h0);
    check("reset clk_o high phase", clk_o, 4'hF);
    half();
    check("reset clk_o low phase", clk_o, 4'h0);

    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    tick();
    check("post-reset ready", divisor_ready_o, 4'hF);
    check("post-reset busy", busy_o, 4'h0);
    check("post-reset period_start", period_start_o, 4'hF);
    measure(3, hi, lo);
    check("post-reset ch3 high", hi, 1);
    check("post-reset ch3 low", lo, 1);

    for (int i = 0; i < 9; i++) begin
      set_div(0, vecs[i].div);
      measure(0, hi, lo);
      measure(0, hi, lo);
      check($sformatf("ch0 d=%0d high", vecs[i].div), hi, vecs[i].exp_hi);
      check($sformatf("ch0 d=%0d low", vecs[i].div), lo, vecs[i].exp_lo);
    end

    // Ch1: d=6 -> d=2 requested so the capture edge lands on cnt=2.
    tick();
    set_div(1, 8'd6);
    g = 0;
    while (!period_start_o[1] && g < 20) begin
      tick();
      g++;
    end
    check("ch1 period start found", period_start_o[1], 1);
    tick();
    check("ch1 ready before request", divisor_ready_o[1], 1);
    divisor_i[1]       = 8'd2;
    divisor_valid_i[1] = 1'b1;
    tick();
    divisor_valid_i[1] = 1'b0;
    check("ch1 ready drops", divisor_ready_o[1], 0);
    busy_cycles = 0;
    g = 0;
    while (busy_o[1] && g < 20) begin
      busy_cycles++;
      tick();
      g++;
    end
    check("ch1 busy cycles", busy_cycles, 4);
    check("ch1 strobe after apply", period_start_o[1], 1);
    check("ch1 ready returns", divisor_ready_o[1], 1);
    measure(1, hi, lo);
    measure(1, hi, lo);
    check("ch1 d=2 high", hi, 2);
    check("ch1 d=2 low", lo, 2);

    // Ch2: gated, DFT transparent, then restart at d=5.
    tick();
    set_div(2, 8'd0);
    tick();
    tick();
    check("ch2 gated period_start", period_start_o[2], 0);
    highs = 0;
    repeat (8) begin
      half();
      if (clk_o[2]) highs++;
    end
    check("ch2 gated clk_o highs", highs, 0);
    test_mode_i = 1'b1;
    tick();
    tick();
    highs = 0;
    repeat (8) begin
      half();
      if (clk_o[2]) highs++;
    end
    check("ch2 test_mode clk_o highs", highs, 4);
    test_mode_i = 1'b0;
    tick();
    tick();
    divisor_i[2]       = 8'd5;
    divisor_valid_i[2] = 1'b1;
    tick();
    divisor_valid_i[2] = 1'b0;
    check("ch2 busy after capture", busy_o[2], 1);
    tick();
    check("ch2 busy cleared", busy_o[2], 0);
    check("ch2 restart strobe", period_start_o[2], 1);
    measure(2, hi, lo);
    measure(2, hi, lo);
    check("ch2 d=5 high", hi, 5);
    check("ch2 d=5 low", lo, 5);

    // Sync realignment of ch0 (d=4) and ch1 (d=6).
    tick();
    set_div(0, 8'd4);
    set_div(1, 8'd6);
    repeat (3) tick();
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    check("sync ch0 strobe", period_start_o[0], 1);
    check("sync ch1 strobe", period_start_o[1], 1);
    both = 0; n0 = 0; n1 = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (period_start_o[0] && period_start_o[1]) both++;
      if (period_start_o[0]) n0++;
      if (period_start_o[1]) n1++;
    end
    check("sync coincident strobes", both, 2);
    check("sync ch0 strobes", n0, 6);
    check("sync ch1 strobes", n1, 4);

    // Asynchronous reset with a pending request on ch1.
    divisor_i[1]       = 8'd3;
    divisor_valid_i[1] = 1'b1;
    tick();
    divisor_valid_i[1] = 1'b0;
    check("pre-reset ch1 busy", busy_o[1], 1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("async reset busy", busy_o, 4'h0);
    check("async reset ready", divisor_ready_o, 4'hF);
    check("async reset period_start", period_start_o, 4'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    tick();
    check("re-release busy", busy_o, 4'h0);
    check("re-release period_start", period_start_o, 4'hF);
    measure(1, hi, lo);
    check("re-release ch1 high", hi, 1);
    check("re-release ch1 low", lo, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
